// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command bytes, frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  localparam int FRAME_BITS = 11;

  // {stop, odd parity, data, start}; bit 0 is the start bit already driven in REQ.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for a raw PS/2 pin with a single-cycle falling-edge strobe.
module ps2_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {2{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      prev_q <= sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift 10 bits on device
// clock falls, check the device ACK, then wait for the bus to return idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, REQ_CYCLES, TIMEOUT_CYCLES) + 1);

  ps2_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  dat_q, dat_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic clk_s, clk_fall, dat_s, unused_dat_fall;

  ps2_sync u_clk_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_i  (ps2_clk_in),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  ps2_sync u_dat_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_i  (ps2_dat_in),
    .sync_o (dat_s),
    .fall_o (unused_dat_fall)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send) begin
          state_d = INHIBIT;
          frame_d = ps2_frame(data);
          cnt_d   = '0;
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          state_d = REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        // Start bit stays low after CLK is released until the first device fall.
        if (cnt_q == CW'(REQ_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          idx_d   = 4'd1;
          dat_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT, ACK, WAIT_IDLE: begin
        cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
        if (!clk_fall && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (state_q == SHIFT) begin
          if (clk_fall) begin
            dat_d = ~frame_q[idx_q];
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd10) state_d = ACK;
          end
        end else if (state_q == ACK) begin
          if (clk_fall) begin
            if (dat_s) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_IDLE;
            end
          end
        end else if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      dat_d = 1'b0;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ);
    ps2_dat_oe = (state_q == REQ) || ((state_q == SHIFT) && dat_q);
  end

  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: open-drain bus with a device model and a
// cycle-level expectation model of busy/done/error and the inhibit/request window.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 6000;
  localparam int REQ  = 50;
  localparam int TO   = 3000;
  localparam int LAT  = 3;            // pin change -> registered FSM reaction
  localparam int NONE = 32'h7fffffff;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       busy, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_lo);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .send(send), .data(data),
    .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 clock = ~clock;

  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, m_end = NONE, half = 20;
  bit m_busy = 1'b0, m_end_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Transaction-level model: accept when idle, end at the cycle the device model predicts.
  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_end  = NONE;
    end else if (send && (!m_busy || cyc >= m_end)) begin
      m_busy  = 1'b1;
      acc_cyc = cyc + 1;
      m_end   = NONE;
    end
    cyc++;
  end

  always @(negedge clock) begin
    int d;
    if (cyc > 0) begin
      if (m_busy && cyc == m_end) begin
        chk("end_done", done, !m_end_err);
        chk("end_error", error, m_end_err);
        chk("end_busy", busy, 0);
        chk("end_clk_oe", ps2_clk_oe, 0);
        chk("end_dat_oe", ps2_dat_oe, 0);
      end else begin
        chk("done_quiet", done, 0);
        chk("error_quiet", error, 0);
        chk("busy", busy, m_busy && cyc < m_end);
        if (!(m_busy && cyc < m_end)) begin
          chk("idle_clk_oe", ps2_clk_oe, 0);
          chk("idle_dat_oe", ps2_dat_oe, 0);
        end else begin
          d = cyc - acc_cyc;
          chk("clk_oe_window", ps2_clk_oe, d < INH + REQ);
          if (d < INH + REQ) chk("dat_oe_window", ps2_dat_oe, d >= INH);
        end
      end
    end
  end

  // mode 0: ACK, 1: NACK, 2: stop clocking after 4 falls, 3: reset after 4 falls
  task automatic dev_frame(input int mode, output logic [10:0] bits);
    int n, nb, last_fall, c;
    bits = '0;
    nb = (mode >= 2) ? 4 : 10;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 10) begin step(1); n++; end
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < INH + REQ + 100) begin step(1); n++; end
    chk("clk_release_seen", n < INH + REQ + 100, 1);
    if (n >= INH + REQ + 100) return;
    chk("clk_release_at", cyc - acc_cyc, INH + REQ);
    bits[0] = ps2_dat_in;
    last_fall = cyc;
    for (int i = 1; i <= nb; i++) begin
      step(half);
      dev_clk_lo = 1'b1;
      last_fall = cyc;
      step(half);
      dev_clk_lo = 1'b0;
      bits[i] = ps2_dat_in;
      if (mode == 2 && i == 2) begin
        data = 8'h5A;
        send = 1'b1;
        step(1);
        send = 1'b0;
      end
    end
    if (mode == 2) begin
      m_end_err = 1'b1;
      m_end = last_fall + LAT + TO;
    end else if (mode == 3) begin
      step(5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
    end else begin
      step(half / 2);
      if (mode == 0) dev_dat_lo = 1'b1;
      step(half / 2);
      dev_clk_lo = 1'b1;
      c = cyc;
      if (mode == 1) begin
        m_end_err = 1'b1;
        m_end = c + LAT;
      end
      step(half);
      dev_clk_lo = 1'b0;
      if (mode == 0) begin
        step(4);
        dev_dat_lo = 1'b0;
        m_end_err = 1'b0;
        m_end = cyc + LAT;
      end
    end
  endtask

  task automatic run_frame(input int mode, input logic [7:0] d, output logic [10:0] bits);
    logic [10:0] exp;
    int k;
    half = $urandom_range(12, 30);
    data = d;
    send = 1'b1;
    step(1);
    send = 1'b0;
    data = 8'($urandom);  // must not affect the latched frame
    dev_frame(mode, bits);
    exp = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    if (mode < 2) chk("frame_bits", bits, exp);
    else          chk("frame_head", bits[4:0], exp[4:0]);
    k = 0;
    while (m_busy && cyc <= m_end && k < TO + 1000) begin step(1); k++; end
    chk("frame_finished", k < TO + 1000, 1);
    step(5);
  endtask

  initial begin
    logic [10:0] bits;
    step(3);
    reset = 1'b0;
    step(2);
    chk("reset_busy", busy, 0);
    chk("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);

    run_frame(0, CMD_SET_LED, bits);
    chk("ed_literal", bits, 11'b11111011010);
    run_frame(0, 8'h00, bits);
    chk("par_00", bits[9], 1);
    run_frame(0, 8'h01, bits);
    chk("par_01", bits[9], 0);
    run_frame(0, CMD_RESET, bits);
    chk("par_ff", bits[9], 1);
    run_frame(0, 8'($urandom), bits);
    run_frame(1, CMD_ENABLE, bits);
    run_frame(2, 8'($urandom), bits);
    run_frame(3, 8'hA5, bits);
    run_frame(0, CMD_ENABLE, bits);
    chk("f4_literal", bits, 11'b10111101000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
